// File: rtl/f_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined FP multiplier among NREQ requesters.
// Optional statistics counters are enabled with `define F_MUL_ARBITER_STATS_EN.
module f_mul_arbiter #(
    parameter int DATA_W  = 32,
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   running,
    input  logic                   run,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic [DATA_W-1:0]      mul_a,
    output logic [DATA_W-1:0]      mul_b,
    input  logic [DATA_W-1:0]      mul_res,
    output logic                   res_valid,
    output logic [ID_W-1:0]        res_id,
    output logic [DATA_W-1:0]      res_data,
    output logic                   busy
`ifdef F_MUL_ARBITER_STATS_EN
    ,
    output logic [31:0]            issue_count,
    output logic [31:0]            conflict_count
`endif
);

    localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NREQ - 1);

    logic [ID_W-1:0]   last;
    logic              grant_en;
    logic              grant_any;
    logic [ID_W-1:0]   grant_id;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [MUL_LAT:0]  tag_valid;
    logic [ID_W-1:0]   tag_id [MUL_LAT+1];

    // rst is included so the grant drops the instant reset is asserted.
    assign grant_en = running & ~run & ~rst;

    always_comb begin
        int idx;
        req_ready = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        if (grant_en) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(last) + k) % NREQ;
                for (int i = 0; i < NREQ; i++) begin
                    if (!grant_any && (i == idx) && req_valid[i]) begin
                        req_ready[i] = 1'b1;
                        grant_id     = ID_W'(i);
                        grant_any    = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_a = req_a[i*DATA_W +: DATA_W];
                sel_b = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a <= '0;
            mul_b <= '0;
            last  <= LAST_INIT;
        end else if (run) begin
            last <= LAST_INIT;
        end else if (grant_any) begin
            mul_a <= sel_a;
            mul_b <= sel_b;
            last  <= grant_id;
        end
    end

    // The multiplier never stalls, so the tag pipeline shifts every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            for (int s = 0; s <= MUL_LAT; s++) tag_id[s] <= '0;
        end else if (run) begin
            tag_valid <= '0;
        end else begin
            tag_valid <= {tag_valid[MUL_LAT-1:0], grant_any};
            tag_id[0] <= grant_id;
            for (int s = 1; s <= MUL_LAT; s++) tag_id[s] <= tag_id[s-1];
        end
    end

    assign res_valid = tag_valid[MUL_LAT];
    assign res_id    = res_valid ? tag_id[MUL_LAT] : '0;
    assign res_data  = res_valid ? mul_res : '0;
    assign busy      = |tag_valid;

`ifdef F_MUL_ARBITER_STATS_EN
    logic multi_req;
    assign multi_req = ($countones(req_valid) > 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_count    <= '0;
            conflict_count <= '0;
        end else if (run) begin
            issue_count    <= '0;
            conflict_count <= '0;
        end else begin
            if (grant_any && (issue_count != '1)) issue_count <= issue_count + 32'd1;
            if (grant_en && multi_req && (conflict_count != '1))
                conflict_count <= conflict_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_f_mul_arbiter.sv
// Self-checking bench for f_mul_arbiter: a queue-based scoreboard checked every cycle
// plus directed scenarios with hand-computed literal expectations.
module tb_f_mul_arbiter;

    localparam int DATA_W  = 32;
    localparam int NREQ    = 4;
    localparam int ID_W    = 2;
    localparam int MUL_LAT = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   running;
    logic                   run;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_a;
    logic [NREQ*DATA_W-1:0] req_b;
    logic [NREQ-1:0]        req_ready;
    logic [DATA_W-1:0]      mul_a;
    logic [DATA_W-1:0]      mul_b;
    logic [DATA_W-1:0]      mul_res;
    logic                   res_valid;
    logic [ID_W-1:0]        res_id;
    logic [DATA_W-1:0]      res_data;
    logic                   busy;
`ifdef F_MUL_ARBITER_STATS_EN
    logic [31:0]            issue_count;
    logic [31:0]            conflict_count;
`endif

    int checks = 0;
    int fails  = 0;

    f_mul_arbiter #(.DATA_W(DATA_W), .NREQ(NREQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .running(running), .run(run),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .busy(busy)
`ifdef F_MUL_ARBITER_STATS_EN
        , .issue_count(issue_count), .conflict_count(conflict_count)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for the external multiplier: exact for the FP vector used, integer product otherwise.
    function automatic logic [31:0] fake_mul(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        return a * b;
    endfunction

    logic [DATA_W-1:0] mul_pipe [MUL_LAT];
    always @(posedge clk) begin
        mul_pipe[0] <= fake_mul(mul_a, mul_b);
        for (int s = 1; s < MUL_LAT; s++) mul_pipe[s] <= mul_pipe[s-1];
    end
    assign mul_res = mul_pipe[MUL_LAT-1];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each accepted request becomes an expected result due MUL_LAT+1 cycles later.
    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          cyc    = 0;
    int          last_m = NREQ - 1;
    logic [31:0] exp_a  = '0;
    logic [31:0] exp_b  = '0;
    int          iss_m  = 0;
    int          conf_m = 0;

    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        bit              any;
        int              gid;
        int              j;
        bit              ev;
        int              eid;
        logic [31:0]     edata;
        cyc++;
        eg = '0; any = 0; gid = 0; j = 0;
        if (running && !run && !rst) begin
            for (int k = 1; k <= NREQ; k++) begin
                j = (last_m + k) % NREQ;
                if (!any && (((req_valid >> j) & 1) != 0)) begin
                    any = 1; gid = j; eg = NREQ'(1) << j;
                end
            end
        end
        ev = 0; eid = 0; edata = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev = 1; eid = q[0].id; edata = q[0].data;
        end
        check_output("cmp_ready", 64'(req_ready), 64'(eg));
        if (rst) begin
            check_output("cmp_rst_valid", 64'(res_valid), 64'd0);
            check_output("cmp_rst_busy", 64'(busy), 64'd0);
            check_output("cmp_rst_mul_a", 64'(mul_a), 64'd0);
            check_output("cmp_rst_mul_b", 64'(mul_b), 64'd0);
        end else begin
            check_output("cmp_res_valid", 64'(res_valid), 64'(ev));
            check_output("cmp_res_id", 64'(res_id), 64'(eid));
            check_output("cmp_res_data", 64'(res_data), 64'(edata));
            check_output("cmp_busy", 64'(busy), 64'(q.size() > 0));
            check_output("cmp_mul_a", 64'(mul_a), 64'(exp_a));
            check_output("cmp_mul_b", 64'(mul_b), 64'(exp_b));
        end
`ifdef F_MUL_ARBITER_STATS_EN
        check_output("cmp_issue_count", 64'(issue_count), rst ? 64'd0 : 64'(iss_m));
        check_output("cmp_conflict_count", 64'(conflict_count), rst ? 64'd0 : 64'(conf_m));
`endif
        if (ev) void'(q.pop_front());
        if (rst) begin
            q.delete(); last_m = NREQ - 1; exp_a = '0; exp_b = '0; iss_m = 0; conf_m = 0;
        end else if (run) begin
            q.delete(); last_m = NREQ - 1; iss_m = 0; conf_m = 0;
        end else begin
            if (running && $countones(req_valid) > 1) conf_m++;
            if (any) begin
                exp_a = req_a[gid*DATA_W +: DATA_W];
                exp_b = req_b[gid*DATA_W +: DATA_W];
                q.push_back('{due: cyc + MUL_LAT + 1, id: gid, data: fake_mul(exp_a, exp_b)});
                last_m = gid;
                iss_m++;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic run_i, input logic running_i, input logic [NREQ-1:0] valid_i);
        run       = run_i;
        running   = running_i;
        req_valid = valid_i;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, '0);
        req_a = '0;
        req_b = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_output("reset_res_valid", 64'(res_valid), 64'd0);
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_mul_a", 64'(mul_a), 64'd0);
        check_output("reset_res_id", 64'(res_id), 64'd0);
        next_cycle();
        rst = 1'b0;

        // Single requester: 2.0 * 3.0 from requester 1.
        req_a[1*DATA_W +: DATA_W] = 32'h4000_0000;
        req_b[1*DATA_W +: DATA_W] = 32'h4040_0000;
        apply_stimulus(1'b0, 1'b1, 4'b0010);
        @(negedge clk);
        check_output("single_ready", 64'(req_ready), 64'h2);
        next_cycle();
        apply_stimulus(1'b0, 1'b1, 4'b0000);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_output("single_busy", 64'(busy), 64'd1);
            check_output("single_res_valid", 64'(res_valid), (k == 5) ? 64'd1 : 64'd0);
            if (k == 5) begin
                check_output("single_res_id", 64'(res_id), 64'd1);
                check_output("single_res_data", 64'(res_data), 64'h40C0_0000);
            end
            next_cycle();
        end
        @(negedge clk);
        check_output("single_busy_end", 64'(busy), 64'd0);
        next_cycle();

        // Distinct operands for every requester from here on.
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*DATA_W +: DATA_W] = 32'h11 + 32'(i);
            req_b[i*DATA_W +: DATA_W] = 32'h101 + 32'(2 * i);
        end

        // Round robin after a run pulse restarts the pointer.
        apply_stimulus(1'b1, 1'b1, 4'b0000);
        next_cycle();
        for (int k = 0; k < 13; k++) begin
            apply_stimulus(1'b0, 1'b1, (k < 8) ? 4'b1111 : 4'b0000);
            @(negedge clk);
            if (k < 8) check_output("rr_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            if (k >= 5) begin
                check_output("rr_res_valid", 64'(res_valid), 64'd1);
                check_output("rr_res_id", 64'(res_id), 64'((k - 5) % 4));
            end
            next_cycle();
        end

        // Pointer skip: req0 granted last, then only 0 and 2 pending.
        apply_stimulus(1'b0, 1'b1, 4'b0001);
        @(negedge clk);
        check_output("skip_ready_first", 64'(req_ready), 64'h1);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 1'b1, 4'b0101);
            @(negedge clk);
            check_output("skip_ready", 64'(req_ready), (k % 2 == 0) ? 64'h4 : 64'h1);
            next_cycle();
        end
        apply_stimulus(1'b0, 1'b1, 4'b0000);
        repeat (6) next_cycle();

        // running low blocks grants but in-flight results drain.
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 1'b0, 4'b1111);
            @(negedge clk);
            check_output("idle_ready", 64'(req_ready), 64'h0);
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 1'b1, 4'b1111);
            @(negedge clk);
            check_output("drain_issue_ready", 64'(req_ready), 64'(4'b0001 << ((3 + k) % 4)));
            next_cycle();
        end
        n = 0;
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1'b0, 1'b0, 4'b1111);
            @(negedge clk);
            check_output("drain_ready", 64'(req_ready), 64'h0);
            if (res_valid) n++;
            next_cycle();
        end
        check_output("drain_result_count", 64'(n), 64'd3);

        // run pulse with four operations in flight.
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b0, 1'b1, 4'b1111);
            @(negedge clk);
            check_output("runclr_issue_ready", 64'(req_ready), 64'(4'b0001 << ((2 + k) % 4)));
            next_cycle();
        end
        apply_stimulus(1'b1, 1'b1, 4'b1111);
        @(negedge clk);
        check_output("runclr_pulse_ready", 64'(req_ready), 64'h0);
        next_cycle();
        apply_stimulus(1'b0, 1'b1, 4'b0000);
        @(negedge clk);
        check_output("runclr_busy", 64'(busy), 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_output("runclr_no_result", 64'(res_valid), 64'd0);
            next_cycle();
        end
        apply_stimulus(1'b0, 1'b1, 4'b1111);
        @(negedge clk);
        check_output("runclr_next_grant", 64'(req_ready), 64'h1);
        next_cycle();

        // Asynchronous reset during sustained issue.
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 1'b1, 4'b1111);
            next_cycle();
        end
        #2;
        rst = 1'b1;
        #1;
        check_output("arst_res_valid", 64'(res_valid), 64'd0);
        check_output("arst_busy", 64'(busy), 64'd0);
        check_output("arst_ready", 64'(req_ready), 64'h0);
        check_output("arst_mul_a", 64'(mul_a), 64'd0);
        check_output("arst_mul_b", 64'(mul_b), 64'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_output("arst_first_grant", 64'(req_ready), 64'h1);
`ifdef F_MUL_ARBITER_STATS_EN
        check_output("arst_issue_count", 64'(issue_count), 64'd0);
        check_output("arst_conflict_count", 64'(conflict_count), 64'd0);
`endif
        next_cycle();
        apply_stimulus(1'b0, 1'b1, 4'b0000);
        repeat (8) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
